spectrum_seq_ctrl: RTL and testbench

SPECTRUM_SEQ_CTRL -- requirements
Module: spectrum_seq_ctrl

---
 rtl/spectrum_seq_ctrl_if.sv | 35 +++
 rtl/spectrum_seq_ctrl.sv | 133 +++++++++++++
 tb/tb_spectrum_seq_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/spectrum_seq_ctrl_if.sv
// Handshake and RAM bus bundle for the spectrum acquisition sequencer.
// master = sequencer side, slave = FFT / RAM / detector / display side.
interface spectrum_seq_ctrl_if;
    logic        start;
    logic        fft_start;
    logic        mag_valid;
    logic [15:0] mag_data;
    logic        ram_we;
    logic [11:0] ram_waddr;
    logic [15:0] ram_wdata;
    logic        det_en;
    logic [11:0] det_rd_addr;
    logic [11:0] disp_rd_addr;
    logic [11:0] ram_raddr;
    logic        det_valid;
    logic [2:0]  det_type;
    logic        busy;
    logic        result_valid;
    logic [2:0]  result_type;
    logic        timeout_err;

    modport master (
        input  start, mag_valid, mag_data, det_rd_addr, disp_rd_addr,
        input  det_valid, det_type,
        output fft_start, ram_we, ram_waddr, ram_wdata, det_en,
        output ram_raddr, busy, result_valid, result_type, timeout_err
    );

    modport slave (
        output start, mag_valid, mag_data, det_rd_addr, disp_rd_addr,
        output det_valid, det_type,
        input  fft_start, ram_we, ram_waddr, ram_wdata, det_en,
        input  ram_raddr, busy, result_valid, result_type, timeout_err
    );
endinterface

// File: rtl/spectrum_seq_ctrl.sv
// Frame sequencer: launches FFT, stores magnitudes, runs the detector
// with a timeout and latches the classification result.
module spectrum_seq_ctrl #(
    parameter int N_POINTS = 4096,
    parameter int TIMEOUT  = 1000000
) (
    input logic                 clk,
    input logic                 rst_n,
    spectrum_seq_ctrl_if.master bus
);

    localparam int CW = (N_POINTS > 1) ? $clog2(N_POINTS) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] W_LAST = CW'(N_POINTS - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        SETTLE,
        DETECT,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] wcnt;
    logic [TW-1:0] tcnt;
    logic          launch;
    logic          wr;
    logic          hit;
    logic          tmo;

    // next-state and per-cycle control decode
    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        wr        = 1'b0;
        hit       = 1'b0;
        tmo       = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    launch    = 1'b1;
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                if (bus.mag_valid) begin
                    wr = 1'b1;
                    if (wcnt == W_LAST) state_nxt = SETTLE;
                end
            end
            SETTLE: state_nxt = DETECT;
            DETECT: begin
                // a detector result on the final cycle beats the timeout
                if (bus.det_valid) begin
                    hit       = 1'b1;
                    state_nxt = DONE;
                end else if (tcnt == T_LAST) begin
                    tmo       = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    launch    = 1'b1;
                    state_nxt = WRITE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // write address counter, saturates on the last bin
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       wcnt <= '0;
        else if (launch)                  wcnt <= '0;
        else if (wr && (wcnt != W_LAST))  wcnt <= wcnt + 1'b1;
    end

    // detect-phase cycle counter, cleared outside DETECT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tcnt <= '0;
        else if ((state == DETECT) && (state_nxt == DETECT))
            tcnt <= tcnt + 1'b1;
        else
            tcnt <= '0;
    end

    // registered pulses, detector enable and result holding
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.fft_start    <= 1'b0;
            bus.det_en       <= 1'b0;
            bus.result_valid <= 1'b0;
            bus.result_type  <= 3'b000;
            bus.timeout_err  <= 1'b0;
        end else begin
            bus.fft_start <= launch;
            bus.det_en    <= (state_nxt == DETECT);
            if (launch) begin
                bus.result_valid <= 1'b0;
                bus.timeout_err  <= 1'b0;
            end else if (hit) begin
                bus.result_type  <= bus.det_type;
                bus.result_valid <= 1'b1;
                bus.timeout_err  <= 1'b0;
            end else if (tmo) begin
                bus.result_type  <= 3'b000;
                bus.result_valid <= 1'b1;
                bus.timeout_err  <= 1'b1;
            end
        end
    end

    // write port is gated so it reads as zero whenever no write happens
    assign bus.ram_we    = wr;
    assign bus.ram_waddr = wr ? 12'(wcnt) : 12'h000;
    assign bus.ram_wdata = wr ? bus.mag_data : 16'h0000;
    assign bus.ram_raddr = (state == DETECT) ? bus.det_rd_addr
                                             : bus.disp_rd_addr;
    assign bus.busy      = (state == WRITE) || (state == SETTLE) ||
                           (state == DETECT);

endmodule

// File: tb/tb_spectrum_seq_ctrl.sv
// Directed bench for spectrum_seq_ctrl with N_POINTS=16, TIMEOUT=50.
module tb_spectrum_seq_ctrl;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   wr_cnt;
    int   fft_cnt;
    int   exp_fft;
    int   n;
    logic [15:0] mem [0:15];
    int   wq[$];

    spectrum_seq_ctrl_if bus ();

    spectrum_seq_ctrl #(
        .N_POINTS (16),
        .TIMEOUT  (50)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model and event counters
    always @(posedge clk) begin
        if (bus.ram_we) begin
            mem[bus.ram_waddr[3:0]] <= bus.ram_wdata;
            wq.push_back(int'(bus.ram_waddr));
            wr_cnt = wr_cnt + 1;
        end
        if (bus.fft_start) fft_cnt = fft_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic fill(input int base);
        for (int k = 0; k < 16; k++) begin
            bus.mag_valid = 1'b1;
            bus.mag_data  = 16'(base + k);
            step();
        end
        bus.mag_valid = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_fft"}, 32'(bus.fft_start), 0);
        chk({tag, "_we"}, 32'(bus.ram_we), 0);
        chk({tag, "_waddr"}, 32'(bus.ram_waddr), 0);
        chk({tag, "_wdata"}, 32'(bus.ram_wdata), 0);
        chk({tag, "_det_en"}, 32'(bus.det_en), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_rv"}, 32'(bus.result_valid), 0);
        chk({tag, "_rt"}, 32'(bus.result_type), 0);
        chk({tag, "_terr"}, 32'(bus.timeout_err), 0);
    endtask

    initial begin
        total = 0; bad = 0; wr_cnt = 0; fft_cnt = 0; exp_fft = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.mag_valid = 1'b1;
        bus.mag_data = 16'hbeef;
        bus.det_valid = 1'b0;
        bus.det_type = 3'b000;
        bus.det_rd_addr = 12'h456;
        bus.disp_rd_addr = 12'h123;
        #12;
        chk_zero("rst");
        step();
        rst_n = 1'b1;
        repeat (3) step();
        chk("idle_ignore_mag", 32'(bus.ram_we), 0);
        bus.mag_valid = 1'b0;
        step();
        chk("idle_no_wr", 32'(wr_cnt), 0);
        chk("idle_no_fft", 32'(fft_cnt), 0);
        chk("idle_raddr", 32'(bus.ram_raddr), 32'h123);

        // normal frame, data = 3*addr, stray start at k=5
        pulse_start();
        exp_fft++;
        chk("nf_fft", 32'(bus.fft_start), 1);
        chk("nf_busy", 32'(bus.busy), 1);
        for (int k = 0; k < 16; k++) begin
            bus.mag_valid = 1'b1;
            bus.mag_data  = 16'(3 * k);
            bus.start     = (k == 5);
            #1;
            chk($sformatf("nf_we%0d", k), 32'(bus.ram_we), 1);
            chk($sformatf("nf_wa%0d", k), 32'(bus.ram_waddr), 32'(k));
            step();
        end
        bus.start = 1'b0;
        bus.mag_valid = 1'b1;
        #1;
        chk("settle_we", 32'(bus.ram_we), 0);
        chk("settle_det_en", 32'(bus.det_en), 0);
        chk("settle_busy", 32'(bus.busy), 1);
        chk("settle_raddr", 32'(bus.ram_raddr), 32'h123);
        step();
        bus.mag_valid = 1'b0;
        chk("det_en_rise", 32'(bus.det_en), 1);
        chk("det_raddr", 32'(bus.ram_raddr), 32'h456);
        repeat (3) step();
        chk("det_rv_low", 32'(bus.result_valid), 0);
        bus.det_valid = 1'b1;
        bus.det_type = 3'b010;
        step();
        bus.det_valid = 1'b0;
        chk("nf_rv", 32'(bus.result_valid), 1);
        chk("nf_rt", 32'(bus.result_type), 32'b010);
        chk("nf_terr", 32'(bus.timeout_err), 0);
        chk("nf_busy_done", 32'(bus.busy), 0);
        chk("nf_det_en_off", 32'(bus.det_en), 0);
        chk("done_raddr", 32'(bus.ram_raddr), 32'h123);
        chk("nf_wr_cnt", 32'(wr_cnt), 16);
        chk("nf_fft_cnt", 32'(fft_cnt), 32'(exp_fft));
        for (int k = 0; k < 16; k++)
            chk($sformatf("nf_mem%0d", k), 32'(mem[k]), 32'(3 * k));
        step();
        chk("done_hold_rt", 32'(bus.result_type), 32'b010);

        // gapped frame ending in timeout
        wq.delete();
        pulse_start();
        exp_fft++;
        chk("gap_rv_clr", 32'(bus.result_valid), 0);
        for (int i = 0; i < 32; i++) begin
            bus.mag_valid = (i % 2 == 0);
            bus.mag_data  = 16'(200 + i / 2);
            #1;
            chk($sformatf("gap_we%0d", i), 32'(bus.ram_we),
                32'(i % 2 == 0));
            step();
        end
        bus.mag_valid = 1'b0;
        chk("gap_wq_size", 32'(wq.size()), 16);
        for (int j = 0; j < 16; j++) begin
            chk($sformatf("gap_addr%0d", j),
                (j < wq.size()) ? 32'(wq[j]) : 32'hffff, 32'(j));
            chk($sformatf("gap_mem%0d", j), 32'(mem[j]), 32'(200 + j));
        end
        chk("to_det_en", 32'(bus.det_en), 1);
        n = 0;
        do begin
            step();
            n++;
        end while (bus.busy && n < 200);
        chk("to_cycles", 32'(n), 50);
        chk("to_terr", 32'(bus.timeout_err), 1);
        chk("to_rt", 32'(bus.result_type), 0);
        chk("to_rv", 32'(bus.result_valid), 1);
        chk("to_det_en_off", 32'(bus.det_en), 0);

        // collision: det_valid on the final timeout cycle
        pulse_start();
        exp_fft++;
        chk("col_terr_clr", 32'(bus.timeout_err), 0);
        fill(0);
        step();
        chk("col_det_en", 32'(bus.det_en), 1);
        repeat (49) step();
        chk("col_busy_pre", 32'(bus.busy), 1);
        bus.det_valid = 1'b1;
        bus.det_type = 3'b100;
        step();
        bus.det_valid = 1'b0;
        chk("col_terr", 32'(bus.timeout_err), 0);
        chk("col_rt", 32'(bus.result_type), 32'b100);
        chk("col_rv", 32'(bus.result_valid), 1);
        chk("col_fft_cnt", 32'(fft_cnt), 32'(exp_fft));

        // asynchronous reset in the middle of WRITE
        pulse_start();
        exp_fft++;
        for (int k = 0; k < 7; k++) begin
            bus.mag_valid = 1'b1;
            bus.mag_data  = 16'(k);
            step();
        end
        bus.mag_data = 16'h7777;
        #1;
        chk("mid_wa7", 32'(bus.ram_waddr), 7);
        n = wr_cnt;
        rst_n = 1'b0;
        #1;
        chk_zero("mid_rst");
        step();
        rst_n = 1'b1;
        repeat (2) step();
        chk("post_rst_no_wr", 32'(wr_cnt), 32'(n));
        chk("post_rst_fft", 32'(fft_cnt), 32'(exp_fft));
        bus.mag_valid = 1'b0;
        pulse_start();
        bus.mag_valid = 1'b1;
        bus.mag_data = 16'habcd;
        #1;
        chk("restart_we", 32'(bus.ram_we), 1);
        chk("restart_wa0", 32'(bus.ram_waddr), 0);
        chk("restart_wd", 32'(bus.ram_wdata), 32'habcd);
        step();
        bus.mag_valid = 1'b0;
        chk("restart_mem0", 32'(mem[0]), 32'habcd);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
